// File: rtl/rr_arbiter_ctrl_pkg.sv
// Shared types and helpers for the round-robin arbiter controller.
// IDW reflects the default WIDTH; modules derive their own index width from their parameter.
package rr_arb_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int IDW       = $clog2(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // OR of the indices of set bits: exact for one-hot input, 0 for zero input.
    // Supports vectors up to 32 bits wide.
    function automatic int unsigned onehot2idx(input logic [31:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_ctrl_if.sv
// Request/grant bundle between requesters (master) and the arbiter controller (slave).
interface rr_arbiter_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int ID_W = $clog2(WIDTH);

    logic [WIDTH-1:0] req;
    logic             done;
    logic [WIDTH-1:0] grant;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_id;
    logic             timeout;

    modport master (
        output req, done,
        input  grant, grant_valid, grant_id, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_valid, grant_id, timeout
    );
endinterface

// File: rtl/rr_arbiter_ctrl_prio.sv
// Combinational lowest-index-first priority arbiter; output is one-hot or zero.
module masked_priority_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant
);
    // Two's complement isolates the lowest set bit.
    assign grant = req & (~req + WIDTH'(1));
endmodule

// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter controller: registered one-hot grant, hold-until-release, one dead cycle.
// Optional forced release after MAX_HOLD busy cycles is enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arbiter_ctrl
    import rr_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_arbiter_ctrl_if.slave bus
);
    localparam int ID_W = $clog2(WIDTH);

    if (WIDTH < 2 || MAX_HOLD < 2) begin : g_bad_params
        $error("rr_arbiter_ctrl: WIDTH and MAX_HOLD must both be >= 2");
    end

    arb_state_t       state_q, state_d;
    logic [WIDTH-1:0] grant_q, grant_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [WIDTH-1:0] masked_req, arb_in, arb_grant;
    logic             owner_release, force_release;

    // Search above the last winner first; wrap to the full request vector when nothing is there.
    assign masked_req = bus.req & mask_q;
    assign arb_in     = (masked_req != '0) ? masked_req : bus.req;

    masked_priority_arbiter #(.WIDTH(WIDTH)) u_prio (
        .req  (arb_in),
        .grant(arb_grant)
    );

    assign owner_release = bus.done || !bus.req[grant_id_q];

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;

    assign force_release = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    // BUSY is only entered from IDLE, so clearing in IDLE is clearing on entry.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        if (state_q == IDLE) begin
            hold_cnt_d = '0;
        end else if (state_q == BUSY) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            timeout_d  = force_release && !owner_release;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign force_release = 1'b0;
    assign bus.timeout   = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        mask_d     = mask_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req != '0) begin
                    state_d    = BUSY;
                    grant_d    = arb_grant;
                    grant_id_d = ID_W'(onehot2idx(32'(arb_grant)));
                end
            end
            BUSY: begin
                if (owner_release || force_release) begin
                    state_d    = RELEASE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    // Bits strictly above the winner; shifting past the top leaves all-zero.
                    mask_d     = {WIDTH{1'b1}} << (32'(grant_id_q) + 32'd1);
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            mask_q     <= '1;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            mask_q     <= mask_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = |grant_q;
    assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Directed self-checking bench for rr_arbiter_ctrl (WIDTH=8, MAX_HOLD=4).
// Covers the forced-release path when RR_ARB_TIMEOUT_EN is defined, unbounded hold otherwise.
module tb_rr_arbiter_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    rr_arbiter_ctrl_if #(.WIDTH(8)) bus ();

    rr_arbiter_ctrl #(.WIDTH(8), .MAX_HOLD(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("miscompare in %s", tag);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp_grant,
                             input logic [2:0] exp_id, input logic exp_timeout);
        check({tag, ".grant"},       32'(bus.grant),       32'(exp_grant));
        check({tag, ".grant_valid"}, 32'(bus.grant_valid), 32'(exp_grant != 8'h00));
        check({tag, ".grant_id"},    32'(bus.grant_id),    32'(exp_id));
        check({tag, ".timeout"},     32'(bus.timeout),     32'(exp_timeout));
    endtask

    initial begin
        bus.req  = 8'h00;
        bus.done = 1'b0;

        // Reset state
        step();
        step();
        check_out("reset", 8'h00, 3'd0, 1'b0);
        rst_n = 1'b1;

        // No requests: nothing happens
        for (int i = 0; i < 5; i++) begin
            step();
            check_out("idle_no_req", 8'h00, 3'd0, 1'b0);
        end

        // Full rotation 0..7 then wrap to 0, done pulsed one cycle after each grant
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            check_out("rot_grant", 8'(8'h01 << (k % 8)), 3'(k % 8), 1'b0);
            step();
            check_out("rot_hold", 8'(8'h01 << (k % 8)), 3'(k % 8), 1'b0);
            bus.done = 1'b1;
            step();
            bus.done = 1'b0;
            check_out("rot_release", 8'h00, 3'd0, 1'b0);
            if (k == 8) bus.req = 8'h00;
            step();
            check_out("rot_idle", 8'h00, 3'd0, 1'b0);
        end

        // Last winner 5, then req=09: mask C0 misses, wrap to id 0, then id 3
        bus.req = 8'h20;
        step();
        check_out("win5", 8'h20, 3'd5, 1'b0);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 8'h09;
        check_out("win5_release", 8'h00, 3'd0, 1'b0);
        step();
        check_out("wrap_idle", 8'h00, 3'd0, 1'b0);
        step();
        check_out("wrap_grant", 8'h01, 3'd0, 1'b0);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        step();
        step();
        check_out("after_wrap_grant", 8'h08, 3'd3, 1'b0);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 8'h00;
        step();

        // Grant id 2 (mask F0 wraps), then withdraw req[2] without done
        bus.req = 8'h04;
        step();
        check_out("win2", 8'h04, 3'd2, 1'b0);
        bus.req = 8'h11;
        step();
        check_out("withdraw_release", 8'h00, 3'd0, 1'b0);
        step();
        check_out("withdraw_idle", 8'h00, 3'd0, 1'b0);
        step();
        check_out("after_withdraw", 8'h10, 3'd4, 1'b0);

        // Reset while id 4 owns the resource: priority restarts at 0
        bus.req = 8'hFF;
        rst_n   = 1'b0;
        step();
        check_out("reset_mid_busy", 8'h00, 3'd0, 1'b0);
        rst_n = 1'b1;
        step();
        check_out("post_reset_grant", 8'h01, 3'd0, 1'b0);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 8'h00;
        step();

        // done while IDLE is ignored
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        check_out("done_in_idle", 8'h00, 3'd0, 1'b0);

        // A new request mid-BUSY does not pre-empt the owner
        bus.req = 8'h02;
        step();
        check_out("win1", 8'h02, 3'd1, 1'b0);
        bus.req = 8'h03;
        step();
        check_out("no_preempt", 8'h02, 3'd1, 1'b0);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 8'h00;
        step();

        // Long hold on id 3 with done low
        bus.req = 8'h08;
`ifdef RR_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            step();
            check_out("hold_before_timeout", 8'h08, 3'd3, 1'b0);
        end
        step();
        check_out("forced_release", 8'h00, 3'd0, 1'b1);
        step();
        check_out("timeout_pulse_end", 8'h00, 3'd0, 1'b0);
        step();
        check_out("rearbitrate", 8'h08, 3'd3, 1'b0);
`else
        for (int i = 0; i < 10; i++) begin
            step();
            check_out("unbounded_hold", 8'h08, 3'd3, 1'b0);
        end
`endif
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 8'h00;
        check_out("final_release", 8'h00, 3'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
